niosii_demo_cpu_cpu_div_cell: RTL
=================================

Name: niosII_demo_cpu_cpu_div_cell

Overview:
- Iterative radix-2 restoring divider. It is the inverse-direction companion to the CPU's 16x16 partial-product multiplier cell.
- Executes div/divu for the Nios II demo core: accepts operands from the E stage, runs one quotient bit per clock, and returns quotient and remainder with a one-cycle done pulse.
- Sits beside the multiplier cell in the CPU execute/memory datapath. The pipeline stalls on busy.

Parameters:
- WIDTH, 32, operand/result width in bits (power of 2, >= 4).
- CNT_W, 5, iteration counter width (= log2(WIDTH)).

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- flush  in  1  abort current operation (pipeline flush).
- signed_op  in  1  1 = div (two's complement), 0 = divu; sampled with start.
- E_src1  in  WIDTH  dividend; sampled with start.
- E_src2  in  WIDTH  divisor; sampled with start.
- busy  out  1  high in RUN and FIX.
- done  out  1  single-cycle pulse; results valid and held afterwards.
- quotient  out  WIDTH  registered quotient.
- remainder  out  WIDTH  registered remainder.
- div_by_zero  out  1  registered; set with done when divisor was 0.

Behaviour:
- Interface (already decided): one clock `clk`; reset `reset` is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0, internal regs 0.
- States: IDLE, RUN, FIX.
- IDLE, start=1 at edge k:
  - Capture sign_q = signed_op & (src1[MSB]^src2[MSB]) and sign_r = signed_op & src1[MSB].
  - Capture |src1| and |src2| (magnitudes only if signed_op; otherwise raw), and the zero-divisor flag.
  - Clear the partial remainder; counter=WIDTH-1; go to RUN.
- RUN, one edge per bit, MSB first:
  - Shift {rem, dividend} left 1 and form trial = rem - divisor (WIDTH+1 bits).
  - If trial is non-negative, rem=trial and the quotient bit is 1; otherwise rem is unchanged and the quotient bit is 0.
  - After WIDTH iterations (edge k+WIDTH) go to FIX.
- FIX, edge k+WIDTH+1:
  - quotient = sign_q ? -q : q; remainder = sign_r ? -r : r.
  - done=1 for exactly one cycle; div_by_zero updated; state to IDLE.
  - Latency: done visible WIDTH+1 clocks after start is sampled (33 for WIDTH=32).
- Divide by zero: runs the full latency with no early exit.
  - Result forced to quotient = all ones, remainder = E_src1 as sampled (unsigned view), div_by_zero=1.
  - Same result for signed and unsigned.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0, div_by_zero=0. This falls out of magnitude arithmetic with wrap-around negation.
- Remainder sign follows the dividend; quotient truncates toward zero.
- start while busy=1: ignored, with no effect on the operation in flight.
- start in the cycle done=1: accepted (state is IDLE); next done follows WIDTH+1 clocks later.
- flush=1 in RUN or FIX: state to IDLE next edge; no done; quotient/remainder/div_by_zero keep previous values.
- flush=1 in IDLE: no effect, and it takes precedence over a simultaneous start (request dropped).
- reset mid-operation: immediate return to reset values; no done.
- Outputs quotient, remainder and div_by_zero hold until the next done.
- No combinational path from inputs to outputs.

Test Plan:
- Unsigned: start, signed_op=0, 100/7 -> done exactly 33 clocks later, quotient=14, remainder=2, busy high 33 cycles, div_by_zero=0.
- Signed: -7/2 (0xFFFFFFF9/0x00000002) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Then 7/-2 -> quotient=0xFFFFFFFD, remainder=0x00000001.
- Corner values:
  - Signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
  - Unsigned 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0.
- Zero divisor: 5/0 (both modes) -> quotient=0xFFFFFFFF, remainder=5, div_by_zero=1 after 33 clocks. Next op 9/3 clears the flag: q=3, r=0.
- Handshake:
  - start pulsed at cycles 5 and 20 of an operation -> single done, result of the first operands only.
  - Back-to-back start on the done cycle -> second done 33 clocks later.
- Abort:
  - flush at iteration 10 -> no done, busy low next cycle, outputs keep the prior result.
  - reset asserted asynchronously mid-RUN -> all outputs 0 immediately; a fresh 100/7 afterwards gives q=14, r=2.

Source files
------------

// File: rtl/niosii_demo_cpu_cpu_div_cell.sv
// niosii_demo_cpu_cpu_div_cell: iterative radix-2 restoring divider for div/divu.
// One quotient bit per clock on magnitudes, sign fix-up in a final cycle, one-cycle done pulse.
`default_nettype none

module niosii_demo_cpu_cpu_div_cell #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] E_src1,
  input  logic [WIDTH-1:0] E_src2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvd;   // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs;
  logic             sign_q;
  logic             sign_r;
  logic             dz;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] src1_mag;
  logic [WIDTH-1:0] src2_mag;
  logic             accept;

  always_comb begin
    shifted  = {rem, dvd[WIDTH-1]};
    trial    = shifted - {1'b0, dvs};
    src1_mag = (signed_op & E_src1[WIDTH-1]) ? -E_src1 : E_src1;
    src2_mag = (signed_op & E_src2[WIDTH-1]) ? -E_src2 : E_src2;
    accept   = (state == S_IDLE) & start & ~flush;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_RUN;
      S_RUN: begin
        if (flush)
          state_nxt = S_IDLE;
        else if (cnt == '0)
          state_nxt = S_FIX;
      end
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      rem         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dz          <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= (state == S_FIX) & ~flush;
      case (state)
        S_IDLE: begin
          if (accept) begin
            sign_q <= signed_op & (E_src1[WIDTH-1] ^ E_src2[WIDTH-1]);
            sign_r <= signed_op & E_src1[WIDTH-1];
            dvd    <= src1_mag;
            dvs    <= src2_mag;
            dz     <= (E_src2 == '0);
            rem    <= '0;
            cnt    <= CNT_W'(WIDTH - 1);
          end
        end
        S_RUN: begin
          if (!flush) begin
            rem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            dvd <= {dvd[WIDTH-2:0], ~trial[WIDTH]};
            cnt <= cnt - 1'b1;
          end
        end
        S_FIX: begin
          // With a zero divisor rem ends up as |src1|, so re-signing restores the raw dividend.
          if (!flush) begin
            quotient    <= dz ? '1 : (sign_q ? -dvd : dvd);
            remainder   <= sign_r ? -rem : rem;
            div_by_zero <= dz;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
